// File: rtl/alu_pkg.sv
// Shared types and constants for the handshaked ALU and its iterative multiplier.
package alu_pkg;

    // Default operand width; must be at least 4 and a power of two.
    localparam int ALU_DATA_WIDTH = 32;
    localparam int ALU_SHAMT_W    = $clog2(ALU_DATA_WIDTH);

    typedef logic [ALU_DATA_WIDTH-1:0] data_t;

    // Opcode encodings; 9..15 are illegal and flagged through out_err.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_MULU = 4'd8
    } op_t;

    // Control states of the pipeline front end.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL      = 2'd1,
        MUL_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// DATA_WIDTH cycles per product. The multiplier operand rides in the low half
// of the accumulator and is shifted out as the product is shifted in.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter  int DATA_WIDTH = ALU_DATA_WIDTH,
    localparam int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic                      busy,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   product
);

    logic [2*DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0]   mcand;
    logic [CNT_W-1:0]        count;
    logic [DATA_WIDTH:0]     partial;
    logic [2*DATA_WIDTH-1:0] acc_step;

    // One shift-add step: add the multiplicand into the high half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    always_comb begin
        partial  = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                 + (acc[0] ? {1'b0, mcand} : '0);
        acc_step = {partial, acc[DATA_WIDTH-1:1]};
    end

    assign busy = (count != '0);
    // done marks the cycle whose edge performs the final step.
    assign done = (count == CNT_W'(1));
    // While busy, expose the post-step value so the final product can be
    // captured on the same edge as the last step; afterwards hold the result.
    assign product = busy ? acc_step : acc;

    // Operand capture on start, then one step per cycle until the count runs out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
            count <= '0;
        end else if (start) begin
            acc   <= {{DATA_WIDTH{1'b0}}, b};
            mcand <= a;
            count <= CNT_W'(DATA_WIDTH);
        end else if (busy) begin
            acc   <= acc_step;
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered results and flags. Single-cycle ops load the
// output registers on accept; MULU runs through the iterative multiplier and
// loads when the output register is free. One operation in flight at a time.
module alu_pipe
    import alu_pkg::*;
#(
    parameter  int DATA_WIDTH = ALU_DATA_WIDTH,
    localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_res,
    output logic [DATA_WIDTH-1:0] out_res_hi,
    output logic                  out_carry,
    output logic                  out_ovf,
    output logic                  out_zero,
    output logic                  out_err
);

    localparam int MSB = DATA_WIDTH - 1;

    state_t                  state_reg;
    logic                    out_free;
    logic                    accept;
    logic                    is_mulu;
    logic                    mul_start;
    logic                    mul_busy;
    logic                    mul_done;
    logic [2*DATA_WIDTH-1:0] mul_product;
    logic [DATA_WIDTH-1:0]   mul_lo;
    logic [DATA_WIDTH-1:0]   mul_hi;

    logic [SHAMT_W-1:0]      shamt;
    logic [DATA_WIDTH:0]     add_full;
    logic [DATA_WIDTH:0]     sub_full;
    logic [DATA_WIDTH-1:0]   alu_res;
    logic                    alu_carry;
    logic                    alu_ovf;
    logic                    alu_err;
    logic                    alu_zero;

    // The output register may take a new value when empty or being drained now.
    assign out_free  = !out_valid || out_ready;
    assign in_ready  = rst_n && (state_reg == IDLE) && !mul_busy && out_free;
    assign accept    = in_valid && in_ready;
    assign is_mulu   = (in_op == OP_MULU);
    assign mul_start = accept && is_mulu;
    assign mul_lo    = mul_product[DATA_WIDTH-1:0];
    assign mul_hi    = mul_product[2*DATA_WIDTH-1:DATA_WIDTH];

    // Shifts only look at the low SHAMT_W bits of in_b.
    assign shamt    = in_b[SHAMT_W-1:0];
    assign add_full = {1'b0, in_a} + {1'b0, in_b};
    assign sub_full = {1'b0, in_a} - {1'b0, in_b};

    alu_mul_seq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath; the extra top bit of add/sub is carry or borrow.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (in_op)
            OP_ADD: begin
                alu_res   = add_full[MSB:0];
                alu_carry = add_full[DATA_WIDTH];
                alu_ovf   = (in_a[MSB] == in_b[MSB]) && (add_full[MSB] != in_a[MSB]);
            end
            OP_SUB: begin
                alu_res   = sub_full[MSB:0];
                alu_carry = sub_full[DATA_WIDTH];
                alu_ovf   = (in_a[MSB] != in_b[MSB]) && (sub_full[MSB] != in_a[MSB]);
            end
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_SLL:  alu_res = in_a << shamt;
            OP_SRL:  alu_res = in_a >> shamt;
            OP_SRA:  alu_res = $signed(in_a) >>> shamt;
            // MULU results come from the multiplier, never from this path.
            OP_MULU: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
        alu_zero = !alu_err && (alu_res == '0);
    end

    // Control FSM with the result/flag registers it loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            out_valid  <= 1'b0;
            out_res    <= '0;
            out_res_hi <= '0;
            out_carry  <= 1'b0;
            out_ovf    <= 1'b0;
            out_zero   <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            // Drained results disappear unless a new one loads below.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (is_mulu) begin
                            state_reg <= MUL;
                        end else begin
                            out_valid  <= 1'b1;
                            out_res    <= alu_res;
                            out_res_hi <= '0;
                            out_carry  <= alu_carry;
                            out_ovf    <= alu_ovf;
                            out_zero   <= alu_zero;
                            out_err    <= alu_err;
                        end
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        if (out_free) begin
                            state_reg  <= IDLE;
                            out_valid  <= 1'b1;
                            out_res    <= mul_lo;
                            out_res_hi <= mul_hi;
                            out_carry  <= (mul_hi != '0);
                            out_ovf    <= 1'b0;
                            out_zero   <= (mul_lo == '0);
                            out_err    <= 1'b0;
                        end else begin
                            state_reg <= MUL_WAIT;
                        end
                    end
                end
                MUL_WAIT: begin
                    if (out_free) begin
                        state_reg  <= IDLE;
                        out_valid  <= 1'b1;
                        out_res    <= mul_lo;
                        out_res_hi <= mul_hi;
                        out_carry  <= (mul_hi != '0);
                        out_ovf    <= 1'b0;
                        out_zero   <= (mul_lo == '0);
                        out_err    <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, hand-written
// backpressure and reset sequences, and a randomized run against a queue
// scoreboard fed by a plain-arithmetic reference model.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        carry;
        logic        ovf;
        logic        zero;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'd0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_res;
    logic [31:0] out_res_hi;
    logic        out_carry;
    logic        out_ovf;
    logic        out_zero;
    logic        out_err;

    int n_checks = 0;
    int n_fail   = 0;

    alu_pipe #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_res_hi (out_res_hi),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .out_zero   (out_zero),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t outs();
        exp_t o;
        o = '{res: out_res, hi: out_res_hi, carry: out_carry, ovf: out_ovf,
              zero: out_zero, err: out_err};
        return o;
    endfunction

    // Reference model written from the arithmetic definitions of each op.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      s;
        logic [63:0] wide;
        logic [31:0] r;
        int          sh;
        e  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        case (op)
            4'd0: begin
                wide    = {32'b0, a} + {32'b0, b};
                e.res   = wide[31:0];
                e.carry = (wide > 64'hFFFF_FFFF);
                s       = sa + sb;
                e.ovf   = (s > SMAX) || (s < SMIN);
            end
            4'd1: begin
                e.res   = a - b;
                e.carry = (a < b);
                s       = sa - sb;
                e.ovf   = (s > SMAX) || (s < SMIN);
            end
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = a ^ b;
            4'd5: e.res = a << sh;
            4'd6: e.res = a >> sh;
            4'd7: begin
                r = a;
                for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
                e.res = r;
            end
            4'd8: begin
                wide    = {32'b0, a} * {32'b0, b};
                e.res   = wide[31:0];
                e.hi    = wide[63:32];
                e.carry = (e.hi != 0);
            end
            default: e.err = 1'b1;
        endcase
        if (!e.err) e.zero = (e.res == 0);
        return e;
    endfunction

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic [31:0] hi,
                                input logic c, input logic o, input logic z, input logic er);
        vec_t v;
        v.op = op; v.a = a; v.b = b;
        v.e  = '{res: res, hi: hi, carry: c, ovf: o, zero: z, err: er};
        return v;
    endfunction

    // Called at a falling edge; issues one op with out_ready high and checks
    // result, flags, latency and in_ready while the op is in flight.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input exp_t e);
        int   lat;
        int   want_lat;
        logic ready_stayed_low;
        want_lat  = (op == 4'd8) ? 32 : 0;
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        ready_stayed_low = 1'b1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_stayed_low = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, want_lat);
        if (want_lat > 0) check({tag, "_busy_in_ready_low"}, ready_stayed_low, 1'b1);
        check({tag, "_res"}, out_res, e.res);
        check({tag, "_res_hi"}, out_res_hi, e.hi);
        check({tag, "_flags_cozE"}, {out_carry, out_ovf, out_zero, out_err},
              {e.carry, e.ovf, e.zero, e.err});
        $display("txn %s op=%0d a=%h b=%h res=%h hi=%h c=%0b o=%0b z=%0b e=%0b lat=%0d",
                 tag, op, a, b, out_res, out_res_hi, out_carry, out_ovf, out_zero, out_err, lat);
    endtask

    function automatic logic [3:0] pick_op();
        int r;
        r = $urandom_range(0, 19);
        if (r < 9)  return 4'(r);
        if (r < 17) return 4'($urandom_range(0, 7));
        return 4'($urandom_range(9, 15));
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[15];
    exp_t q[$];
    exp_t e_tmp;

    initial begin
        logic acc;
        logic cons;
        logic stray;

        vecs[0]  = mk(OP_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0, 1, 0, 1, 0);
        vecs[1]  = mk(OP_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 32'h0, 0, 1, 0, 0);
        vecs[2]  = mk(OP_SUB,  32'h3,         32'h5,         32'hFFFF_FFFE, 32'h0, 1, 0, 0, 0);
        vecs[3]  = mk(OP_SRA,  32'h8000_0000, 32'h23,        32'hF000_0000, 32'h0, 0, 0, 0, 0);
        vecs[4]  = mk(OP_SLL,  32'h1,         32'd31,        32'h8000_0000, 32'h0, 0, 0, 0, 0);
        vecs[5]  = mk(4'hF,    32'h5,         32'h7,         32'h0,         32'h0, 0, 0, 0, 1);
        vecs[6]  = mk(OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0, 0, 0, 0, 0);
        vecs[7]  = mk(OP_OR,   32'h0,         32'h0,         32'h0,         32'h0, 0, 0, 1, 0);
        vecs[8]  = mk(OP_XOR,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0,         32'h0, 0, 0, 1, 0);
        vecs[9]  = mk(OP_SRL,  32'h8000_0000, 32'h3F,        32'h1,         32'h0, 0, 0, 0, 0);
        vecs[10] = mk(OP_SUB,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 32'h0, 0, 1, 0, 0);
        vecs[11] = mk(4'h9,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0, 0, 0, 0, 1);
        vecs[12] = mk(OP_SUB,  32'h5,         32'h5,         32'h0,         32'h0, 0, 0, 1, 0);
        vecs[13] = mk(OP_MULU, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFE, 32'h1, 1, 0, 0, 0);
        vecs[14] = mk(OP_MULU, 32'h0,         32'h5,         32'h0,         32'h0, 0, 0, 1, 0);

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_outputs", outs(), exp_t'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);
        end

        // Backpressure: hold the first result three cycles, then stream
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1; in_op = OP_ADD; in_a = 32'd10; in_b = 32'd1;
        @(posedge clk);
        #1 in_a = 32'd20; in_b = 32'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", i), out_valid, 1'b1);
            check($sformatf("bp_hold%0d_res", i), out_res, 32'd11);
            check($sformatf("bp_hold%0d_flags", i), {out_carry, out_ovf, out_zero, out_err}, 4'b0000);
            check($sformatf("bp_hold%0d_in_ready", i), in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1 check("bp_release_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_a = 32'd30; in_b = 32'd3;
        @(negedge clk);
        check("bp_second_valid", out_valid, 1'b1);
        check("bp_second_res", out_res, 32'd22);
        $display("txn bp_second res=%h", out_res);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_third_valid", out_valid, 1'b1);
        check("bp_third_res", out_res, 32'd33);
        $display("txn bp_third res=%h", out_res);
        @(negedge clk);
        check("bp_no_duplicate", out_valid, 1'b0);

        // Reset in the middle of a multiply
        in_valid = 1'b1; in_op = OP_MULU; in_a = 32'h1234_5678; in_b = 32'h9;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midmul_rst_out_valid", out_valid, 1'b0);
        check("midmul_rst_outputs", outs(), exp_t'(0));
        check("midmul_rst_in_ready", in_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        e_tmp = '{res: 32'd2, hi: 32'd0, carry: 1'b0, ovf: 1'b0, zero: 1'b0, err: 1'b0};
        run_op("post_rst_add", OP_ADD, 32'd1, 32'd1, e_tmp);
        stray = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) stray = 1'b1;
        end
        check("post_rst_no_partial_product", stray, 1'b0);

        // Randomized traffic against the scoreboard
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (out_valid) begin
                check("rnd_queue_nonempty", q.size() != 0, 1'b1);
                if (q.size() != 0) check($sformatf("rnd_result_c%0d", cyc), outs(), q[0]);
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = pick_op();
            in_a      = pick_val();
            in_b      = pick_val();
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            @(posedge clk);
            if (cons) begin
                $display("txn rnd res=%h hi=%h c=%0b o=%0b z=%0b e=%0b",
                         out_res, out_res_hi, out_carry, out_ovf, out_zero, out_err);
                if (q.size() != 0) void'(q.pop_front());
            end
            if (acc) q.push_back(model(in_op, in_a, in_b));
            @(negedge clk);
        end

        // Drain whatever is still in flight
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 80 && (q.size() != 0 || out_valid); i++) begin
            if (out_valid && q.size() != 0) check("drain_result", outs(), q[0]);
            #1;
            cons = out_valid;
            @(posedge clk);
            if (cons && q.size() != 0) void'(q.pop_front());
            @(negedge clk);
        end
        check("drain_queue_empty", q.size(), 0);
        check("drain_out_valid", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
